// File: rtl/feedback_scorer_if.sv
// Operand/result bundle between the guess-history stage and the peg scorer.
// Latency: none, wiring only.
// Backpressure: none; start is simply ignored while the scorer is busy or the game is over.
interface feedback_scorer_if #(
    parameter int COLOR_W = 3
);
    logic               start;
    logic [COLOR_W-1:0] guess3, guess2, guess1, guess0;
    logic [COLOR_W-1:0] secret3, secret2, secret1, secret0;
    logic               last_turn;
    logic [2:0]         exact;
    logic [2:0]         partial;
    logic               busy;
    logic               done;
    logic               win;
    logic               game_over;

    // Requester side: drives the operands, watches the score.
    modport master (
        output start, guess3, guess2, guess1, guess0,
        output secret3, secret2, secret1, secret0, last_turn,
        input  exact, partial, busy, done, win, game_over
    );

    // Scorer side.
    modport slave (
        input  start, guess3, guess2, guess1, guess0,
        input  secret3, secret2, secret1, secret0, last_turn,
        output exact, partial, busy, done, win, game_over
    );
endinterface

// File: rtl/feedback_scorer.sv
// Mastermind-style scorer: counts exact and colour-only peg matches of a latched guess vs secret.
// Latency: done pulses in the cycle after the 9th rising edge following the accepting edge.
// Backpressure: start is accepted only in IDLE with game_over low; otherwise it is dropped.
module feedback_scorer #(
    parameter int CODE_LEN = 4,
    parameter int COLOR_W  = 3
) (
    input  logic          clk,
    input  logic          reset,
    feedback_scorer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXACT   = 2'd1,
        S_PARTIAL = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           idx;
    logic [COLOR_W-1:0]   g_q [CODE_LEN];
    logic [COLOR_W-1:0]   s_q [CODE_LEN];
    logic [CODE_LEN-1:0]  g_used, s_used;
    logic [2:0]           ex_cnt, pa_cnt;
    logic                 last_q;
    logic [2:0]           exact_q, partial_q;
    logic                 done_q, win_q, over_q;

    logic                 accept;
    logic                 ex_hit;
    logic                 pm_hit;
    logic [1:0]           pm_pos;

    assign accept = (state == S_IDLE) && bus.start && !over_q;
    assign ex_hit = (g_q[idx] == s_q[idx]);

    // Lowest-numbered uncredited secret peg whose colour matches the current guess peg.
    always_comb begin
        pm_hit = 1'b0;
        pm_pos = 2'd0;
        for (int j = CODE_LEN - 1; j >= 0; j--) begin
            if (!s_used[j] && (s_q[j] == g_q[idx])) begin
                pm_hit = 1'b1;
                pm_pos = 2'(j);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: two four-cycle sweeps, then one report cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_EXACT;
            S_EXACT:   if (idx == 2'(CODE_LEN - 1)) state_nxt = S_PARTIAL;
            S_PARTIAL: if (idx == 2'(CODE_LEN - 1)) state_nxt = S_REPORT;
            S_REPORT:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, match flags, counters and registered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= 2'd0;
            g_used    <= '0;
            s_used    <= '0;
            ex_cnt    <= 3'd0;
            pa_cnt    <= 3'd0;
            last_q    <= 1'b0;
            exact_q   <= 3'd0;
            partial_q <= 3'd0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            over_q    <= 1'b0;
            for (int i = 0; i < CODE_LEN; i++) begin
                g_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        g_q[0] <= bus.guess0;
                        g_q[1] <= bus.guess1;
                        g_q[2] <= bus.guess2;
                        g_q[3] <= bus.guess3;
                        s_q[0] <= bus.secret0;
                        s_q[1] <= bus.secret1;
                        s_q[2] <= bus.secret2;
                        s_q[3] <= bus.secret3;
                        last_q <= bus.last_turn;
                        g_used <= '0;
                        s_used <= '0;
                        ex_cnt <= 3'd0;
                        pa_cnt <= 3'd0;
                        idx    <= 2'd0;
                    end
                end
                S_EXACT: begin
                    if (ex_hit) begin
                        g_used[idx] <= 1'b1;
                        s_used[idx] <= 1'b1;
                        ex_cnt      <= ex_cnt + 3'd1;
                    end
                    idx <= idx + 2'd1;
                end
                S_PARTIAL: begin
                    if (!g_used[idx] && pm_hit) begin
                        s_used[pm_pos] <= 1'b1;
                        pa_cnt         <= pa_cnt + 3'd1;
                    end
                    idx <= idx + 2'd1;
                end
                S_REPORT: begin
                    exact_q   <= ex_cnt;
                    partial_q <= pa_cnt;
                    done_q    <= 1'b1;
                    win_q     <= (ex_cnt == 3'd4);
                    if ((ex_cnt == 3'd4) || last_q) begin
                        over_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.exact     = exact_q;
    assign bus.partial   = partial_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.win       = win_q;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_feedback_scorer.sv
// Randomised + directed bench for feedback_scorer against a colour-histogram score model.
// Latency: checks done lands exactly 9 edges after the accepting edge.
// Backpressure: checks start is dropped while busy and once the game is over.
module tb_feedback_scorer;
    logic clk;
    logic reset;

    feedback_scorer_if #(.COLOR_W(3)) bus ();

    feedback_scorer #(.CODE_LEN(4), .COLOR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state for outputs that persist between passes.
    int ex_m   = 0;
    int pa_m   = 0;
    bit win_m  = 0;
    bit over_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Pack pegs so that position 0 is the first listed.
    function automatic logic [11:0] pk(input int p0, input int p1, input int p2, input int p3);
        logic [11:0] v;
        v = {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
        return v;
    endfunction

    // Score by counting: exact positions, then per-colour min of leftover counts.
    task automatic model(input logic [11:0] s, input logic [11:0] g, output int ex, output int pa);
        int cs [8];
        int cg [8];
        int sp, gp;
        ex = 0;
        pa = 0;
        for (int c = 0; c < 8; c++) begin
            cs[c] = 0;
            cg[c] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            sp = int'(s[i*3 +: 3]);
            gp = int'(g[i*3 +: 3]);
            if (sp == gp) ex++;
            else begin
                cs[sp]++;
                cg[gp]++;
            end
        end
        for (int c = 0; c < 8; c++) pa += (cs[c] < cg[c]) ? cs[c] : cg[c];
    endtask

    task automatic drive_ops(input logic [11:0] s, input logic [11:0] g, input logic lt);
        bus.secret0 = s[2:0];  bus.secret1 = s[5:3];
        bus.secret2 = s[8:6];  bus.secret3 = s[11:9];
        bus.guess0  = g[2:0];  bus.guess1  = g[5:3];
        bus.guess2  = g[8:6];  bus.guess3  = g[11:9];
        bus.last_turn = lt;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".exact"},     32'(bus.exact),     0);
        check({tag, ".partial"},   32'(bus.partial),   0);
        check({tag, ".busy"},      32'(bus.busy),      0);
        check({tag, ".done"},      32'(bus.done),      0);
        check({tag, ".win"},       32'(bus.win),       0);
        check({tag, ".game_over"}, 32'(bus.game_over), 0);
    endtask

    // Called at a falling edge; releases on the next falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        bus.start = 1'b0;
        #1;
        check_zero(tag);
        ex_m = 0; pa_m = 0; win_m = 0; over_m = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One start request, observed for 12 edges; disturb perturbs inputs and re-pulses start mid-pass.
    task automatic run_pass(input logic [11:0] s, input logic [11:0] g, input logic lt,
                            input bit disturb, input string tag);
        int ex, pa, dones, first_k;
        bit acc, busy_seen;
        model(s, g, ex, pa);
        acc = !over_m;
        drive_ops(s, g, lt);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0; first_k = 0; busy_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (disturb && k <= 4) begin
                drive_ops(12'($urandom), 12'($urandom), ~lt);
                bus.start = (k % 2 == 1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                if (first_k == 0) first_k = k;
            end
            if (bus.busy === 1'b1) busy_seen = 1;
            if (acc && k == 1) check({tag, ".busy_k1"}, 32'(bus.busy), 1);
            if (acc && k == 8) check({tag, ".busy_k8"}, 32'(bus.busy), 1);
            if (acc && k == 9) check({tag, ".busy_k9"}, 32'(bus.busy), 0);
        end
        if (acc) begin
            ex_m = ex; pa_m = pa; win_m = (ex == 4);
            over_m = over_m || win_m || lt;
            check({tag, ".done_cnt"}, 32'(dones), 1);
            check({tag, ".latency"},  32'(first_k), 9);
        end else begin
            check({tag, ".done_cnt"},  32'(dones), 0);
            check({tag, ".busy_seen"}, 32'(busy_seen), 0);
        end
        check({tag, ".exact"},     32'(bus.exact),     32'(ex_m));
        check({tag, ".partial"},   32'(bus.partial),   32'(pa_m));
        check({tag, ".win"},       32'(bus.win),       32'(win_m));
        check({tag, ".game_over"}, 32'(bus.game_over), 32'(over_m));
    endtask

    initial begin
        logic [11:0] rs, rg;
        logic        rlt;
        int          dones;

        reset = 1'b0;
        bus.start = 1'b0;
        drive_ops(12'd0, 12'd0, 1'b0);
        #2;
        check_zero("por");
        @(negedge clk);
        reset = 1'b1;

        run_pass(pk(1,2,3,4), pk(1,2,3,4), 1'b0, 0, "win");
        do_reset("rst_after_win");
        run_pass(pk(1,2,3,4), pk(4,3,2,1), 1'b0, 0, "allpartial");
        run_pass(pk(5,5,1,2), pk(5,1,5,5), 1'b0, 0, "dup_a");
        run_pass(pk(1,1,2,2), pk(1,2,1,0), 1'b0, 0, "dup_b");
        run_pass(pk(3,6,3,0), pk(2,3,0,3), 1'b0, 1, "disturb");
        run_pass(pk(7,6,5,4), pk(0,0,0,0), 1'b1, 0, "lastturn");
        run_pass(pk(1,2,3,4), pk(1,2,3,4), 1'b0, 0, "after_over");
        do_reset("rst_after_over");

        // Abort a pass while in the partial sweep.
        run_pass(pk(1,2,3,4), pk(1,3,2,4), 1'b0, 0, "pre_abort");
        drive_ops(pk(2,2,2,2), pk(2,2,2,2), 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero("abort");
        ex_m = 0; pa_m = 0; win_m = 0; over_m = 0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("abort.no_done", 32'(dones), 0);
        check("abort.busy_after", 32'(bus.busy), 0);
        run_pass(pk(1,2,3,4), pk(2,1,3,7), 1'b0, 0, "post_abort");

        // Random passes; small colour range in half of them to force duplicates.
        for (int n = 0; n < 60; n++) begin
            if (n % 2 == 0) begin
                rs = 12'($urandom);
                rg = 12'($urandom);
            end else begin
                rs = pk($urandom_range(0,2), $urandom_range(0,2), $urandom_range(0,2), $urandom_range(0,2));
                rg = pk($urandom_range(0,2), $urandom_range(0,2), $urandom_range(0,2), $urandom_range(0,2));
            end
            rlt = ($urandom_range(0,9) == 0);
            run_pass(rs, rg, rlt, ($urandom_range(0,3) == 0), "rand");
            if (over_m && ($urandom_range(0,1) == 0)) begin
                run_pass(rg, rs, 1'b0, 0, "rand_over");
            end
            if (over_m) do_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
